led_blinker_mc: RTL and testbench

//   Multi-channel LED blink/PWM peripheral for the PicoRV32 SoC. It replaces the single hard-wired blink LED.

---
 rtl/led_blinker_pkg.sv | 43 ++++
 rtl/led_blink_channel.sv | 158 +++++++++++++++
 rtl/led_blinker_mc.sv | 116 +++++++++++
 tb/tb_led_blinker_mc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/led_blinker_pkg.sv
// Shared definitions for the multi-channel LED blinker.
//   - mode encodings held in CTRL[1:0]
//   - per-channel register offsets (low two word-address bits)
//   - STATUS / CTRL field positions
//   - bus handshake FSM encoding
//   - byte-strobe merge helper used by every writable register
package led_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_ONTIME = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int STATUS_RUNNING_BIT = 0;
  localparam int STATUS_DONE_BIT    = 1;
  localparam int STATUS_REMAIN_LSB  = 8;
  localparam int CTRL_COUNT_LSB     = 8;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Replace only the byte lanes selected by strb.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: CTRL/PERIOD/ONTIME registers, period counter,
// one-shot pulse counter, sticky done flag and the led output.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   wr_en                commit a write to this channel on this edge
//   wr_reg/wr_data/wr_strb  register index, data and byte strobes of the write
//   rd_reg               register index for the combinational read port
//   rd_data              read value (unused bits are 0)
//   led                  LED output, 1 = lit
//   done                 sticky one-shot completion flag
module led_blink_channel
  import led_blinker_pkg::*;
#(
  parameter int CNT_WIDTH   = 24,
  parameter int PULSE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_reg,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic [1:0]  rd_reg,
  output logic [31:0] rd_data,
  output logic        led,
  output logic        done
);

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = 1;
  localparam logic [PULSE_WIDTH-1:0] PULSE_ONE = 1;

  mode_e                  mode_q,    mode_d;
  logic [PULSE_WIDTH-1:0] count_q,   count_d;
  logic [CNT_WIDTH-1:0]   period_q,  period_d;
  logic [CNT_WIDTH-1:0]   ontime_q,  ontime_d;
  logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
  logic [PULSE_WIDTH-1:0] remain_q,  remain_d;
  logic                   running_q, running_d;
  logic                   done_q,    done_d;

  logic [31:0] ctrl_img, status_img;
  logic [31:0] ctrl_new, period_new, ontime_new;
  logic        ctrl_wr, period_wr, ontime_wr, status_clr;
  logic        wrap, done_set;
  logic        unused_bits;

  assign ctrl_img   = (32'(count_q) << CTRL_COUNT_LSB) | {30'b0, mode_q};
  assign status_img = (32'(remain_q) << STATUS_REMAIN_LSB)
                    | {30'b0, done_q, running_q};

  assign ctrl_new   = apply_wstrb(ctrl_img, wr_data, wr_strb);
  assign period_new = apply_wstrb(32'(period_q), wr_data, wr_strb);
  assign ontime_new = apply_wstrb(32'(ontime_q), wr_data, wr_strb);
  // Field extraction drops the upper bits of the merged words.
  assign unused_bits = ^{ctrl_new, period_new, ontime_new};

  assign ctrl_wr    = wr_en && (wr_reg == REG_CTRL);
  assign period_wr  = wr_en && (wr_reg == REG_PERIOD);
  assign ontime_wr  = wr_en && (wr_reg == REG_ONTIME);
  assign status_clr = wr_en && (wr_reg == REG_STATUS) && wr_strb[0]
                      && wr_data[STATUS_DONE_BIT];

  // >= rather than == so that shrinking PERIOD below cnt wraps at once.
  assign wrap = running_q && (cnt_q >= period_q);

  always_comb begin
    mode_d    = mode_q;
    count_d   = count_q;
    period_d  = period_q;
    ontime_d  = ontime_q;
    cnt_d     = cnt_q;
    remain_d  = remain_q;
    running_d = running_q;
    done_set  = 1'b0;

    if (period_wr) period_d = period_new[CNT_WIDTH-1:0];
    if (ontime_wr) ontime_d = ontime_new[CNT_WIDTH-1:0];

    if (ctrl_wr) begin
      // A CTRL write always restarts the channel and beats a coincident wrap.
      mode_d    = mode_e'(ctrl_new[1:0]);
      count_d   = ctrl_new[CTRL_COUNT_LSB +: PULSE_WIDTH];
      cnt_d     = '0;
      running_d = (mode_d == MODE_BLINK) || (mode_d == MODE_ONESHOT);
      remain_d  = (mode_d == MODE_ONESHOT) ? count_d : '0;
    end else begin
      if (running_q) cnt_d = wrap ? '0 : cnt_q + CNT_ONE;
      else           cnt_d = '0;

      if (running_q && (mode_q == MODE_ONESHOT)) begin
        if (remain_q == '0) begin
          // Pulse count of zero: finish one clock after the CTRL write.
          running_d = 1'b0;
          done_set  = 1'b1;
        end else if (wrap) begin
          remain_d = remain_q - PULSE_ONE;
          if (remain_q == PULSE_ONE) begin
            running_d = 1'b0;
            done_set  = 1'b1;
          end
        end
      end
    end

    // Set beats a simultaneous software clear.
    if (done_set)        done_d = 1'b1;
    else if (status_clr) done_d = 1'b0;
    else                 done_d = done_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_OFF;
      count_q   <= '0;
      period_q  <= '0;
      ontime_q  <= '0;
      cnt_q     <= '0;
      remain_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      count_q   <= count_d;
      period_q  <= period_d;
      ontime_q  <= ontime_d;
      cnt_q     <= cnt_d;
      remain_q  <= remain_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    led = 1'b0;
    case (mode_q)
      MODE_OFF:     led = 1'b0;
      MODE_ON:      led = 1'b1;
      MODE_BLINK:   led = cnt_q < ontime_q;
      // remain_q != 0 keeps a zero-count one-shot dark for its single cycle.
      MODE_ONESHOT: led = running_q && (remain_q != '0) && (cnt_q < ontime_q);
      default:      led = 1'b0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (rd_reg)
      REG_CTRL:   rd_data = ctrl_img;
      REG_PERIOD: rd_data = 32'(period_q);
      REG_ONTIME: rd_data = 32'(ontime_q);
      REG_STATUS: rd_data = status_img;
      default:    rd_data = '0;
    endcase
  end

  assign done = done_q;

endmodule

// File: rtl/led_blinker_mc.sv
// Multi-channel LED blink/PWM peripheral on the PicoRV32 native bus.
// Holds the bus handshake FSM, address decode, read mux and irq OR;
// each channel lives in led_blink_channel.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   mem_valid/mem_addr         request and word address {channel, reg[1:0]}
//   mem_wstrb/mem_wdata        byte strobes (0 = read) and write data
//   mem_rdata/mem_ready        read data and one-cycle acknowledge
//   led                        per-channel LED outputs
//   irq                        registered OR of all done flags
// Handshake: a request seen in IDLE is committed on the next edge, which
// also raises mem_ready for exactly one cycle together with mem_rdata;
// mem_rdata is 0 whenever mem_ready is 0.
module led_blinker_mc
  import led_blinker_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 24,
  parameter int PULSE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_valid,
  input  logic [$clog2(CHANNELS)+1:0] mem_addr,
  input  logic [3:0]                  mem_wstrb,
  input  logic [31:0]                 mem_wdata,
  output logic [31:0]                 mem_rdata,
  output logic                        mem_ready,
  output logic [CHANNELS-1:0]         led,
  output logic                        irq
);

  localparam int AW = $clog2(CHANNELS) + 2;

  bus_state_e bus_state_q, bus_state_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        irq_q, irq_d;

  logic          req, is_write, in_range;
  logic [AW-1:0] chan_idx;
  logic [31:0]   rd_mux;
  logic [31:0]   ch_rd [CHANNELS];
  logic [CHANNELS-1:0] ch_done;

  assign req      = (bus_state_q == BUS_IDLE) && mem_valid;
  assign is_write = |mem_wstrb;
  assign chan_idx = mem_addr >> 2;
  assign in_range = chan_idx < AW'(CHANNELS);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_blink_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .PULSE_WIDTH(PULSE_WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (reset),
      .wr_en  (req && is_write && (chan_idx == AW'(i))),
      .wr_reg (mem_addr[1:0]),
      .wr_data(mem_wdata),
      .wr_strb(mem_wstrb),
      .rd_reg (mem_addr[1:0]),
      .rd_data(ch_rd[i]),
      .led    (led[i]),
      .done   (ch_done[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_idx == AW'(i)) rd_mux = ch_rd[i];
    end
  end

  // Bus FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus_state_q <= BUS_IDLE;
    else       bus_state_q <= bus_state_d;
  end

  // Bus FSM: next state.
  always_comb begin
    bus_state_d = bus_state_q;
    case (bus_state_q)
      BUS_IDLE: if (mem_valid) bus_state_d = BUS_ACK;
      BUS_ACK:  bus_state_d = BUS_IDLE;
      default:  bus_state_d = BUS_IDLE;
    endcase
  end

  // Bus FSM: outputs.
  always_comb begin
    mem_ready = (bus_state_q == BUS_ACK);
  end

  // Read data is captured with the request and cleared on every other edge.
  always_comb begin
    mem_rdata_d = '0;
    if (req && !is_write && in_range) mem_rdata_d = rd_mux;
    irq_d = |ch_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      mem_rdata_q <= mem_rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_led_blinker_mc.sv
module tb_led_blinker_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [3:0]  led;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  led_blinker_mc #(.CHANNELS(4), .CNT_WIDTH(24), .PULSE_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .led      (led),
    .irq      (irq)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction: request at a falling edge, acknowledge one cycle later.
  task automatic xfer(input logic [3:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rdata);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    mem_wstrb = strb;
    check("ready_low_at_req", {31'b0, mem_ready}, 32'd0);
    @(negedge clk);
    check("ready_ack", {31'b0, mem_ready}, 32'd1);
    rdata     = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    xfer(addr, data, 4'hf, dummy);
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    xfer(addr, 32'd0, 4'h0, v);
    check(tag, v, exp);
  endtask

  initial begin
    logic [31:0] v;
    logic        b;

    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = 4'd0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_led", {28'b0, led}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    reset = 1'b0;

    // Bus timing and byte strobes on ch2 PERIOD (addr 9).
    wr(4'd9, 32'hFFABCDEF);
    rd("period_full", 4'd9, 32'h00ABCDEF);
    xfer(4'd9, 32'hFFFFFF12, 4'b0001, v);
    @(negedge clk);
    check("ready_one_cycle", {31'b0, mem_ready}, 32'd0);
    check("rdata_zero_idle", mem_rdata, 32'd0);
    rd("period_byte0", 4'd9, 32'h00ABCD12);

    // ch0 BLINK: PERIOD=9, ONTIME=3 -> 3 high, 7 low.
    wr(4'd1, 32'd9);
    wr(4'd2, 32'd3);
    wr(4'd0, 32'd2);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      b = (k % 10) < 3;
      check("blink_ch0", {28'b0, led}, {28'b0, 3'b000, b});
    end

    // ch1 ONESHOT count 3, PERIOD=4, ONTIME=2.
    wr(4'd0, 32'd0);
    wr(4'd5, 32'd4);
    wr(4'd6, 32'd2);
    wr(4'd4, 32'h303);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      b = (k < 15) && ((k % 5) < 2);
      check("oneshot_ch1", {28'b0, led}, {28'b0, 2'b00, b, 1'b0});
    end
    check("oneshot_irq", {31'b0, irq}, 32'd1);
    rd("oneshot_status", 4'd7, 32'h2);
    wr(4'd7, 32'h2);
    check("irq_before_clear", {31'b0, irq}, 32'd1);
    @(negedge clk);
    check("irq_after_clear", {31'b0, irq}, 32'd0);
    rd("status_cleared", 4'd7, 32'h0);

    // Boundaries on ch2: ONTIME=0 dark, ONTIME=PERIOD+1 lit.
    wr(4'd9, 32'd5);
    wr(4'd10, 32'd0);
    wr(4'd8, 32'd2);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      check("ontime0", {28'b0, led}, 32'h0);
    end
    wr(4'd10, 32'd6);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      check("ontime_gt_period", {28'b0, led}, 32'h4);
    end

    // ch3 ONESHOT count 0: done one clock after the write, irq one later.
    wr(4'd12, 32'h3);
    check("cnt0_led", {28'b0, led}, 32'h4);
    check("cnt0_irq_t0", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("cnt0_led_t1", {28'b0, led}, 32'h4);
    check("cnt0_irq_t1", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("cnt0_irq_t2", {31'b0, irq}, 32'd1);
    rd("cnt0_status", 4'd15, 32'h2);
    wr(4'd15, 32'h2);
    wr(4'd8, 32'd0);

    // CTRL rewrite on ch1's wrap edge reloads remaining without a decrement.
    wr(4'd4, 32'h203);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("rewrite_pre", {31'b0, led[1]}, {31'b0, k < 2});
    end
    wr(4'd4, 32'h203);
    check("rewrite_k0", {31'b0, led[1]}, 32'd1);
    rd("rewrite_status", 4'd7, 32'h201);
    check("rewrite_k2", {31'b0, led[1]}, 32'd0);
    for (int k = 3; k < 15; k++) begin
      @(negedge clk);
      b = (k < 10) && ((k % 5) < 2);
      check("rewrite_pulse", {31'b0, led[1]}, {31'b0, b});
    end
    check("rewrite_irq", {31'b0, irq}, 32'd1);
    rd("rewrite_done", 4'd7, 32'h2);
    wr(4'd7, 32'h2);

    // Shrinking ch0 PERIOD below cnt wraps on the next clock.
    wr(4'd2, 32'd1);
    wr(4'd0, 32'd2);
    repeat (5) @(negedge clk);
    wr(4'd1, 32'd2);
    check("shrink_cnt7", {31'b0, led[0]}, 32'd0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      check("shrink_wrap", {31'b0, led[0]}, {31'b0, ((j - 1) % 3) == 0});
    end

    // Reset mid-BLINK, with irq set and a transaction in its ACK cycle.
    wr(4'd8, 32'h3);
    repeat (2) @(negedge clk);
    check("pre_reset_irq", {31'b0, irq}, 32'd1);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 4'd8;
    mem_wstrb = 4'd0;
    @(posedge clk);
    #2;
    check("pre_reset_ready", {31'b0, mem_ready}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_led", {28'b0, led}, 32'd0);
    check("async_irq", {31'b0, irq}, 32'd0);
    check("async_ready", {31'b0, mem_ready}, 32'd0);
    check("async_rdata", mem_rdata, 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd("post_reset_reg", 4'(a), 32'd0);
    end
    check("post_reset_led", {28'b0, led}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
